// File: rtl/cp_pkg.sv
// Shared core-pipeline definitions: default datapath geometry, the data word
// type, and the busy-bit update rule used by the register file and its scoreboard.
package cp_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;

  typedef logic [DEF_DATA_W-1:0] data_t;

  // A new producer claim beats a retiring write to the same register.
  function automatic logic next_busy(input logic cur, input logic issue_hit,
                                     input logic write_hit);
    return issue_hit ? 1'b1 : (write_hit ? 1'b0 : cur);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending-producer flag per architectural register,
// set by issue and cleared by the matching write-back.
module reg_scoreboard
  import cp_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int R0_ZERO  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_addr,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                iss_en;

  assign iss_en = issue_valid && !(R0_ZERO != 0 && issue_addr == '0);

  // NOTE: give every always_comb output a value on every path (here via the
  // full loop) so no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_d[i] = next_busy(busy_q[i], iss_en && issue_addr == AW'(i),
                            we && waddr == AW'(i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Two-read/one-write register file with write-through bypass and a per-register
// busy scoreboard; read data and busy flags are registered (1-cycle latency).
module reg_file_mp
  import cp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int R0_ZERO  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_addr,
  input  logic [AW-1:0]       raddr_a,
  input  logic [AW-1:0]       raddr_b,
  output logic [DATA_W-1:0]   rdata_a,
  output logic [DATA_W-1:0]   rdata_b,
  output logic                busy_a,
  output logic                busy_b,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic              busy_a_q, busy_a_d, busy_b_q, busy_b_d;
  logic              wr_en, iss_en;

  // With R0_ZERO, register 0 is never written, so it holds its reset zero.
  assign wr_en  = we && !(R0_ZERO != 0 && waddr == '0);
  assign iss_en = issue_valid && !(R0_ZERO != 0 && issue_addr == '0);

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW),
    .R0_ZERO  (R0_ZERO)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .we          (we),
    .waddr       (waddr),
    .busy_vec    (busy_vec)
  );

  // NOTE: the array is reset explicitly because a reset must leave every
  // register reading zero; this rules out a RAM macro, which is intended.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Outputs report the post-edge view: same-cycle writes and claims bypass.
  always_comb begin
    rdata_a_d = regs_q[raddr_a];
    rdata_b_d = regs_q[raddr_b];
    if (wr_en && waddr == raddr_a) rdata_a_d = wdata;
    if (wr_en && waddr == raddr_b) rdata_b_d = wdata;
    busy_a_d = next_busy(busy_vec[raddr_a], iss_en && issue_addr == raddr_a,
                         we && waddr == raddr_a);
    busy_b_d = next_busy(busy_vec[raddr_b], iss_en && issue_addr == raddr_b,
                         we && waddr == raddr_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      busy_a_q  <= 1'b0;
      busy_b_q  <= 1'b0;
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      busy_a_q  <= busy_a_d;
      busy_b_q  <= busy_b_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign busy_a  = busy_a_q;
  assign busy_b  = busy_b_q;

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 16, register width in bits.
REQ-002 Parameter NUM_REGS, default 8, register count; power of two, at least 2.
REQ-003 Parameter AW, default $clog2(NUM_REGS), address width.
REQ-004 Parameter R0_ZERO, default 0; when 1, register 0 always reads zero and is never busy.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 we  input  1  write strobe.
REQ-008 waddr  input  AW  write address.
REQ-009 wdata  input  DATA_W  write data.
REQ-010 issue_valid  input  1  marks register issue_addr busy (pending producer).
REQ-011 issue_addr  input  AW  register being claimed.
REQ-012 raddr_a / raddr_b  input  AW  read addresses, ports A/B.
REQ-013 rdata_a / rdata_b  output  DATA_W  registered read data, ports A/B.
REQ-014 busy_a / busy_b  output  1  registered busy flag of the addressed register.
REQ-015 busy_vec  output  NUM_REGS  current busy bit per register (bit i = register i).

Function
REQ-016 Storage SHALL update only on a rising clk edge with we=1: reg[waddr] <= wdata.
REQ-017 Reads SHALL have 1-cycle latency: rdata_x at edge N+1 reflects raddr_x sampled at edge N.
REQ-018 Write-through bypass SHALL apply: we=1 and waddr==raddr_x in the same cycle means rdata_x next cycle equals wdata.
REQ-019 Both read ports SHALL be independent; identical addresses on A and B SHALL return identical data.
REQ-020 With R0_ZERO=1, writes to address 0 SHALL be ignored, reads of 0 SHALL return 0 including the bypass case, and issue to 0 SHALL not set busy.
REQ-021 Busy bit i SHALL set on issue_valid with issue_addr==i.
REQ-022 Busy bit i SHALL clear on we with waddr==i.
REQ-023 Simultaneous issue and write to the same register: issue SHALL win and the bit remains or becomes set (new producer).
REQ-024 Issue and write to different registers in the same cycle SHALL both take effect.
REQ-025 busy_x SHALL use the same bypass rule as data: it reports the post-edge busy state of raddr_x.
REQ-026 busy_vec SHALL be the registered busy state, with no bypass.
REQ-027 Out-of-range addresses cannot occur, because NUM_REGS is a power of two.

Reset
REQ-028 rst=1 at a clk edge SHALL clear all registers, all busy bits, rdata_a, rdata_b, busy_a, busy_b and busy_vec to 0.
REQ-029 Reset SHALL override we and issue_valid in the same cycle.
REQ-030 A mid-operation reset SHALL discard all pending busy claims, and the first post-reset read SHALL return 0.

Structure
REQ-031 Package cp_pkg SHALL hold the DATA_W and NUM_REGS default constants and the typedef data_t (logic [DATA_W-1:0]), shared with the ALU and datapath.
REQ-032 The busy-bit logic SHALL be the single sub-module reg_scoreboard, with ports clk, rst, issue_valid, issue_addr, we, waddr and busy_vec.
REQ-033 Storage SHALL be an inferred flop array with no vendor primitives.

Verification
REQ-034 Reset: rst=1 for 2 cycles, then read A=3 and B=7 -> rdata_a=0, rdata_b=0, busy_vec=0.
REQ-035 Write/read: write r5=16'h1234, next cycle read A=5 -> rdata_a=16'h1234 one cycle later.
REQ-036 Bypass: in one cycle write r2=16'hBEEF and read B=2 -> rdata_b=16'hBEEF the next cycle, not the old value.
REQ-037 Scoreboard race: issue r4, then one cycle later issue r4 together with a write to r4 -> busy_vec[4] stays 1; a following write-only cycle to r4 -> busy_vec[4]=0.
REQ-038 R0_ZERO=1: write r0=16'hFFFF while issuing r0 and reading A=0 -> rdata_a=0, busy_vec[0]=0.
REQ-039 Mid-operation reset: write r1=16'h00AA and issue r6, then rst=1 -> r1 reads 0, busy_vec=0.
